tl_sensor_cond: RTL and testbench

//  Conditions the two raw car-presence sensors (street A, street B) into the clean Ta/Tb

---
 rtl/tl_sensor_cond_if.sv | 14 +
 rtl/tl_sensor_cond.sv | 54 +++++
 tb/tb_tl_sensor_cond.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tl_sensor_cond_if.sv
// tl_sensor_cond_if: raw sensor inputs and conditioned outputs of the sensor conditioner
//   sa_raw/sb_raw  raw street sensors (master drives)
//   Ta/Tb          conditioned traffic present (slave drives)
//   a_arr/b_arr    one-cycle arrival pulses (slave drives)
interface tl_sensor_cond_if;
  logic sa_raw;
  logic sb_raw;
  logic Ta;
  logic Tb;
  logic a_arr;
  logic b_arr;
  modport master(output sa_raw, sb_raw, input Ta, Tb, a_arr, b_arr);
  modport slave(input sa_raw, sb_raw, output Ta, Tb, a_arr, b_arr);
endinterface

// File: rtl/tl_sensor_cond.sv
// tl_sensor_cond: synchronise, debounce and hold-stretch the two car-presence sensors
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      slave side: sa_raw/sb_raw in; Ta/Tb, a_arr/b_arr out
module tl_sensor_cond #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int CW          = 8
) (
  input logic        clk,
  input logic        reset_n,
  tl_sensor_cond_if.slave bus
);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);
  logic [1:0] raw;
  logic [1:0] t;
  logic [1:0] arr;
  assign raw = {bus.sb_raw, bus.sa_raw};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          s1_q, s2_q, f_q, f_d, arr_q, flip;
    logic [CW-1:0] cnt_q, cnt_d, hold_q, hold_d;
    // flip marks the edge on which the filtered level takes the synchronised value
    always_comb begin
      flip   = (s2_q != f_q) && (cnt_q == DB_LAST);
      f_d    = flip ? s2_q : f_q;
      cnt_d  = (s2_q == f_q || flip) ? '0 : cnt_q + 1'b1;
      hold_d = flip ? (f_q ? HOLD_INIT : '0) : (hold_q != '0 ? hold_q - 1'b1 : hold_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        f_q    <= 1'b0;
        cnt_q  <= '0;
        hold_q <= '0;
        arr_q  <= 1'b0;
      end else begin
        s1_q   <= raw[c];
        s2_q   <= s1_q;
        f_q    <= f_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        arr_q  <= flip & ~f_q;
      end
    end
    assign t[c]   = f_q | (hold_q != '0);
    assign arr[c] = arr_q;
  end
  assign bus.Ta    = t[0];
  assign bus.Tb    = t[1];
  assign bus.a_arr = arr[0];
  assign bus.b_arr = arr[1];
endmodule

// File: tb/tb_tl_sensor_cond.sv
// tb_tl_sensor_cond: scoreboard bench for tl_sensor_cond (DB_CYCLES=4, HOLD_CYCLES=10)
module tb_tl_sensor_cond;
  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ev_t;
  logic clk;
  logic reset_n;
  int   cyc;
  int   asserts;
  int   fails;
  ev_t  exp_q[$];
  logic [3:0] prev;
  tl_sensor_cond_if bus();
  tl_sensor_cond #(.DB_CYCLES(4), .HOLD_CYCLES(10), .CW(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [3:0] outs();
    return {bus.Ta, bus.Tb, bus.a_arr, bus.b_arr};
  endfunction
  task automatic push(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_now(input string name, input logic [3:0] req);
    logic [3:0] act;
    act = outs();
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: outputs {Ta,Tb,a_arr,b_arr}=%b, required %b", name, act, req);
    end
  endtask
  // Monitor: every change of the output vector is an event that must match the queue head.
  initial prev = 4'b0000;
  always @(negedge clk) begin
    logic [3:0] v;
    ev_t e;
    v = outs();
    if (!reset_n) prev = v;
    else if (v !== prev) begin
      prev = v;
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event: unexpected output change at cycle %0d to %b", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== v) begin
          fails++;
          $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d", v, cyc, e.vec, e.cyc);
        end
      end
    end
  end
  initial begin
    int t;
    asserts = 0;
    fails = 0;
    reset_n = 1'b1;
    bus.sa_raw = 1'b0;
    bus.sb_raw = 1'b0;
    #3 reset_n = 1'b0;
    #1 check_now("reset_initial", 4'b0000);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(2);
    // clean arrival on A: Ta and a_arr 5 edges after first sample
    t = cyc;
    bus.sa_raw = 1'b1;
    push(t + 6, 4'b1010);
    push(t + 7, 4'b1000);
    wait_neg(12);
    // departure: f falls at t+6, Ta held through 10 more edges
    t = cyc;
    bus.sa_raw = 1'b0;
    push(t + 16, 4'b0000);
    wait_neg(20);
    // bounce: 3 high, 1 low, 3 high, low; never reaches f
    bus.sa_raw = 1'b1;
    wait_neg(3);
    bus.sa_raw = 1'b0;
    wait_neg(1);
    bus.sa_raw = 1'b1;
    wait_neg(3);
    bus.sa_raw = 1'b0;
    wait_neg(12);
    // re-arrival four cycles into hold: Ta stays high, one new a_arr pulse
    t = cyc;
    bus.sa_raw = 1'b1;
    push(t + 6, 4'b1010);
    push(t + 7, 4'b1000);
    wait_neg(12);
    t = cyc;
    bus.sa_raw = 1'b0;
    push(t + 16, 4'b1010);
    push(t + 17, 4'b1000);
    wait_neg(10);
    bus.sa_raw = 1'b1;
    wait_neg(12);
    t = cyc;
    bus.sa_raw = 1'b0;
    push(t + 16, 4'b0000);
    wait_neg(20);
    // both streets together
    t = cyc;
    bus.sa_raw = 1'b1;
    bus.sb_raw = 1'b1;
    push(t + 6, 4'b1111);
    push(t + 7, 4'b1100);
    wait_neg(10);
    check_now("both_high", 4'b1100);
    // asynchronous reset mid-cycle with both outputs high
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_now("reset_async", 4'b0000);
    wait_neg(2);
    check_now("reset_held", 4'b0000);
    t = cyc;
    reset_n = 1'b1;
    push(t + 6, 4'b1111);
    push(t + 7, 4'b1100);
    wait_neg(10);
    t = cyc;
    bus.sa_raw = 1'b0;
    bus.sb_raw = 1'b0;
    push(t + 16, 4'b0000);
    wait_neg(20);
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never observed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
